string_stream_gen: RTL and testbench

- Parametrised successor to the long-string-parameter test block.
- Stores an elaboration-time string parameter of up to MAX_CHARS characters and streams it out as an AXI-stream byte frame.
- Output is DSIZE bytes per beat, with tkeep and tlast.
- Supports one-shot and repeat modes with a programmable inter-frame gap.
- Used for banners, init sequences and loopback test patterns.

---
 rtl/string_stream_pkg.sv | 24 ++
 rtl/string_stream_gen.sv | 100 ++++++++++
 tb/tb_string_stream_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/string_stream_pkg.sv
// string_stream_pkg: shared state type and string helpers for string_stream_gen
package string_stream_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam int STR_MAX_CHARS = 256;
    localparam int STR_BITS = 8 * STR_MAX_CHARS;

    function automatic int str_eff_len(input logic [STR_BITS-1:0] v, input int max_chars);
        int n;
        n = max_chars;
        for (int i = STR_MAX_CHARS - 1; i >= 0; i--)
            if (i < max_chars && n == i + 1 && v[8*i +: 8] == 8'h00) n = i;
        return n;
    endfunction

    // Character 0 is the most significant non-padding byte.
    function automatic logic [7:0] str_char(input logic [STR_BITS-1:0] v, input int l, input int idx);
        int p;
        p = (idx >= 0 && idx < l) ? l - 1 - idx : 0;
        return (idx >= 0 && idx < l) ? v[8*p +: 8] : 8'h00;
    endfunction

endpackage

// File: rtl/string_stream_gen.sv
// string_stream_gen: streams a constant string as AXI-stream byte frames, one-shot or repeating
module string_stream_gen
    import string_stream_pkg::*;
#(
    parameter int MAX_CHARS = 111,
    parameter logic [8*MAX_CHARS-1:0] INIT_STR = "ppppppppp",
    parameter int DSIZE = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 repeat_en,
    output logic                 busy,
    output logic                 done,
    output logic [8*DSIZE-1:0]   m_tdata,
    output logic [DSIZE-1:0]     m_tkeep,
    output logic                 m_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready
);

    localparam logic [STR_BITS-1:0] STR_EXT = STR_BITS'(INIT_STR);
    localparam int L = str_eff_len(STR_EXT, MAX_CHARS);
    localparam int IW = $clog2(MAX_CHARS + 1);

    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [7:0] gap_cnt, gap_n;
    logic done_n, valid_n, busy_n, last_n;
    logic [8*DSIZE-1:0] data_n;
    logic [DSIZE-1:0] keep_n;

    always_comb begin
        state_n = state;
        idx_n = idx;
        gap_n = gap_cnt;
        done_n = 1'b0;
        if (state == IDLE) begin
            if (start && L > 0) begin
                state_n = SEND;
                idx_n = '0;
            end else if (start) begin
                done_n = 1'b1;
            end
        end else if (state == GAP) begin
            gap_n = gap_cnt - 8'd1;
            if (gap_cnt == 8'd0) begin
                state_n = SEND;
                idx_n = '0;
            end
        end else if (m_tvalid && m_tready) begin
            if (!m_tlast) begin
                idx_n = idx + IW'(DSIZE);
            end else if (!repeat_en) begin
                state_n = IDLE;
                done_n = 1'b1;
            end else if (GAP_CYCLES == 0) begin
                idx_n = '0;
            end else begin
                state_n = GAP;
                gap_n = 8'(GAP_CYCLES - 1);
            end
        end
        valid_n = state_n == SEND;
        busy_n = state_n != IDLE;
        last_n = valid_n && (int'(idx_n) + DSIZE >= L);
    end

    // Beat contents derive from the next index, so a stalled beat recomputes identically.
    for (genvar j = 0; j < DSIZE; j++) begin : g_lane
        assign data_n[8*j +: 8] = valid_n ? str_char(STR_EXT, L, int'(idx_n) + j) : 8'h00;
        assign keep_n[j] = valid_n && (int'(idx_n) + j < L);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            gap_cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            m_tvalid <= 1'b0;
            m_tlast <= 1'b0;
            m_tdata <= '0;
            m_tkeep <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            gap_cnt <= gap_n;
            busy <= busy_n;
            done <= done_n;
            m_tvalid <= valid_n;
            m_tlast <= last_n;
            m_tdata <= data_n;
            m_tkeep <= keep_n;
        end
    end

endmodule

// File: tb/tb_string_stream_gen.sv
// tb_string_stream_gen: directed checks of string_stream_gen across several parameter sets
module tb_string_stream_gen;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst = 1'b1;
    logic repeat_en = 1'b0;
    logic [4:0] start = '0;
    logic [4:0] ready = '1;
    logic [4:0] busy, done, valid, last;
    logic [7:0] d0, d4;
    logic [31:0] d1, d3;
    logic [15:0] d2;
    logic [0:0] k0, k4;
    logic [3:0] k1, k3;
    logic [1:0] k2;

    int n_cmp = 0;
    int n_err = 0;

    string_stream_gen u0 (.clock(clock), .rst(rst), .start(start[0]), .repeat_en(repeat_en),
        .busy(busy[0]), .done(done[0]), .m_tdata(d0), .m_tkeep(k0), .m_tlast(last[0]),
        .m_tvalid(valid[0]), .m_tready(ready[0]));

    string_stream_gen #(.INIT_STR("ABCDEFGHIJ"), .DSIZE(4)) u1 (.clock(clock), .rst(rst),
        .start(start[1]), .repeat_en(repeat_en), .busy(busy[1]), .done(done[1]), .m_tdata(d1),
        .m_tkeep(k1), .m_tlast(last[1]), .m_tvalid(valid[1]), .m_tready(ready[1]));

    string_stream_gen #(.INIT_STR("ABCDEFGHIJ"), .DSIZE(2)) u2 (.clock(clock), .rst(rst),
        .start(start[2]), .repeat_en(1'b0), .busy(busy[2]), .done(done[2]), .m_tdata(d2),
        .m_tkeep(k2), .m_tlast(last[2]), .m_tvalid(valid[2]), .m_tready(ready[2]));

    string_stream_gen #(.DSIZE(4), .GAP_CYCLES(2)) u3 (.clock(clock), .rst(rst),
        .start(start[3]), .repeat_en(repeat_en), .busy(busy[3]), .done(done[3]), .m_tdata(d3),
        .m_tkeep(k3), .m_tlast(last[3]), .m_tvalid(valid[3]), .m_tready(ready[3]));

    string_stream_gen #(.INIT_STR("")) u4 (.clock(clock), .rst(rst), .start(start[4]),
        .repeat_en(1'b0), .busy(busy[4]), .done(done[4]), .m_tdata(d4), .m_tkeep(k4),
        .m_tlast(last[4]), .m_tvalid(valid[4]), .m_tready(ready[4]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    logic [31:0] e1d [3] = '{32'h44434241, 32'h48474645, 32'h00004A49};
    logic [3:0]  e1k [3] = '{4'hF, 4'hF, 4'h3};
    logic [15:0] e2d [5] = '{16'h4241, 16'h4443, 16'h4645, 16'h4847, 16'h4A49};
    logic [31:0] e3d [3] = '{32'h70707070, 32'h70707070, 32'h00000070};
    logic [3:0]  e3k [3] = '{4'hF, 4'hF, 4'h1};

    initial begin
        int hs, beats;
        bit held, fin;
        logic [15:0] hd;
        logic [1:0] hk;
        logic hl;
        repeat (3) tick;
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_last", 64'(last), 64'h0);
        chk("rst_data", 64'({d0, d1, d2}), 64'h0);
        chk("rst_keep", 64'({k0, k1, k2, k3}), 64'h0);
        rst = 1'b0;
        repeat (6) tick;

        // default 9-char frame, with a start pulse mid-frame that must be ignored
        start[0] = 1'b1; tick; start[0] = 1'b0;
        for (int b = 0; b < 9; b++) begin
            chk($sformatf("t1_valid_b%0d", b), 64'(valid[0]), 64'h1);
            chk($sformatf("t1_data_b%0d", b), 64'(d0), 64'h70);
            chk($sformatf("t1_keep_b%0d", b), 64'(k0), 64'h1);
            chk($sformatf("t1_last_b%0d", b), 64'(last[0]), 64'(b == 8));
            chk($sformatf("t1_busy_b%0d", b), 64'(busy[0]), 64'h1);
            if (b == 4) start[0] = 1'b1;
            tick;
            start[0] = 1'b0;
        end
        chk("t1_done", 64'(done[0]), 64'h1);
        chk("t1_busy_end", 64'(busy[0]), 64'h0);
        chk("t1_valid_end", 64'(valid[0]), 64'h0);
        tick;
        chk("t1_done_pulse", 64'(done[0]), 64'h0);
        chk("t1_no_refire", 64'(valid[0]), 64'h0);

        // DSIZE=4 packing and partial final keep
        start[1] = 1'b1; tick; start[1] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("t2_valid_b%0d", b), 64'(valid[1]), 64'h1);
            chk($sformatf("t2_data_b%0d", b), 64'(d1), 64'(e1d[b]));
            chk($sformatf("t2_keep_b%0d", b), 64'(k1), 64'(e1k[b]));
            chk($sformatf("t2_last_b%0d", b), 64'(last[1]), 64'(b == 2));
            tick;
        end
        chk("t2_done", 64'(done[1]), 64'h1);

        // DSIZE=2 under random backpressure
        start[2] = 1'b1; tick; start[2] = 1'b0;
        hs = 0; held = 1'b0; fin = 1'b0; hd = '0; hk = '0; hl = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (held) begin
                chk("t3_hold_valid", 64'(valid[2]), 64'h1);
                chk("t3_hold_data", 64'(d2), 64'(hd));
                chk("t3_hold_keep", 64'(k2), 64'(hk));
                chk("t3_hold_last", 64'(last[2]), 64'(hl));
            end
            ready[2] = 1'($urandom_range(0, 1));
            if (valid[2] && ready[2]) begin
                if (hs < 5) chk($sformatf("t3_data_h%0d", hs), 64'(d2), 64'(e2d[hs]));
                chk($sformatf("t3_keep_h%0d", hs), 64'(k2), 64'h3);
                if (last[2]) fin = 1'b1;
                hs++;
            end
            held = valid[2] && !ready[2];
            hd = d2; hk = k2; hl = last[2];
            tick;
        end
        ready[2] = 1'b1;
        chk("t3_finished", 64'(fin), 64'h1);
        chk("t3_handshakes", 64'(hs), 64'd5);
        chk("t3_done", 64'(done[2]), 64'h1);

        // repeat mode with a 2-cycle gap; repeat_en dropped during frame 3
        repeat_en = 1'b1;
        start[3] = 1'b1; tick; start[3] = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            for (int b = 0; b < 3; b++) begin
                chk($sformatf("t4_valid_f%0d_b%0d", f, b), 64'(valid[3]), 64'h1);
                chk($sformatf("t4_data_f%0d_b%0d", f, b), 64'(d3), 64'(e3d[b]));
                chk($sformatf("t4_keep_f%0d_b%0d", f, b), 64'(k3), 64'(e3k[b]));
                chk($sformatf("t4_last_f%0d_b%0d", f, b), 64'(last[3]), 64'(b == 2));
                if (f == 3 && b == 0) repeat_en = 1'b0;
                tick;
            end
            if (f < 3) begin
                for (int g = 0; g < 2; g++) begin
                    chk($sformatf("t4_gap_f%0d_g%0d", f, g), 64'(valid[3]), 64'h0);
                    chk($sformatf("t4_gap_busy_f%0d_g%0d", f, g), 64'(busy[3]), 64'h1);
                    chk($sformatf("t4_gap_done_f%0d_g%0d", f, g), 64'(done[3]), 64'h0);
                    tick;
                end
            end
        end
        chk("t4_done", 64'(done[3]), 64'h1);
        chk("t4_valid_end", 64'(valid[3]), 64'h0);
        tick;
        chk("t4_idle_busy", 64'(busy[3]), 64'h0);
        chk("t4_idle_valid", 64'(valid[3]), 64'h0);

        // reset during beat 4, then start with reset, then a clean restart
        start[0] = 1'b1; tick; start[0] = 1'b0;
        repeat (4) tick;
        chk("t5_beat4_valid", 64'(valid[0]), 64'h1);
        rst = 1'b1; tick; rst = 1'b0;
        chk("t5_rst_valid", 64'(valid[0]), 64'h0);
        chk("t5_rst_busy", 64'(busy[0]), 64'h0);
        chk("t5_rst_done", 64'(done[0]), 64'h0);
        tick;
        chk("t5_no_done", 64'(done[0]), 64'h0);
        rst = 1'b1; start[0] = 1'b1; tick; rst = 1'b0; start[0] = 1'b0;
        chk("t5_rst_wins_valid", 64'(valid[0]), 64'h0);
        chk("t5_rst_wins_busy", 64'(busy[0]), 64'h0);
        tick;
        chk("t5_rst_wins_after", 64'(valid[0]), 64'h0);
        start[0] = 1'b1; tick; start[0] = 1'b0;
        chk("t5_restart_char0", 64'(d0), 64'h70);
        beats = 0;
        for (int c = 0; c < 30 && !done[0]; c++) begin
            if (valid[0] && ready[0]) beats++;
            tick;
        end
        chk("t5_restart_done", 64'(done[0]), 64'h1);
        chk("t5_restart_beats", 64'(beats), 64'd9);

        // empty string: done only, never valid
        start[4] = 1'b1; tick; start[4] = 1'b0;
        chk("t6_done", 64'(done[4]), 64'h1);
        chk("t6_valid", 64'(valid[4]), 64'h0);
        chk("t6_busy", 64'(busy[4]), 64'h0);
        for (int c = 0; c < 4; c++) begin
            tick;
            chk($sformatf("t6_quiet_c%0d", c), 64'({done[4], valid[4]}), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
